// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU host command front end.
package tpu_pkg;

  localparam int DEF_N           = 4;
  localparam int DEF_DW          = 8;
  localparam int DEF_UB_AW       = 12;
  localparam int DEF_MMU_TIMEOUT = 256;

  // Counter width covers the largest UB load (4095 beats) and the MMU timeout.
  localparam int CNT_W = 12;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 29;
  localparam int IMM_MSB = 11;

  typedef enum logic [2:0] {
    NOP              = 3'd0,
    READ_HOST_MEMORY = 3'd1,
    READ_WEIGHTS     = 3'd2,
    MATRIX_MULTIPLY  = 3'd3
  } tpu_instruction_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_W    = 3'd1,
    LOAD_UB   = 3'd2,
    MMU_START = 3'd3,
    MMU_WAIT  = 3'd4
  } tpu_state_e;

  function automatic logic [2:0] get_opcode(input logic [31:0] instr);
    return instr[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [CNT_W-1:0] get_beat_count(input logic [CNT_W-1:0] imm,
                                                       input logic [CNT_W-1:0] full);
    return (imm == {CNT_W{1'b0}}) ? full : imm;
  endfunction

endpackage

// File: rtl/tpu_host_ctrl_if.sv
// Host instruction/data, weight/UB load and MMU handshake signals of the host front end.
interface tpu_host_ctrl_if
  import tpu_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DW    = DEF_DW,
  parameter int UB_AW = DEF_UB_AW
);
  localparam int LG = $clog2(N);

  logic             host_instruction_valid;
  logic [31:0]      host_instruction;
  logic             host_instruction_ready;
  logic [DW-1:0]    host_write_data;
  logic             host_wdata_valid;
  logic [UB_AW-1:0] host_write_address;
  logic             weight_wr_en;
  logic [LG-1:0]    weight_wr_row;
  logic [LG-1:0]    weight_wr_col;
  logic [DW-1:0]    weight_wr_data;
  logic             ub_wr_en;
  logic [UB_AW-1:0] ub_wr_addr;
  logic [DW-1:0]    ub_wr_data;
  logic             mmu_start;
  logic             mmu_done;
  logic             busy;
  logic             err_illegal;
  logic             err_dropped;
  logic             err_timeout;

  modport master (
    output host_instruction_valid, host_instruction, host_write_data,
           host_wdata_valid, host_write_address, mmu_done,
    input  host_instruction_ready, weight_wr_en, weight_wr_row, weight_wr_col,
           weight_wr_data, ub_wr_en, ub_wr_addr, ub_wr_data, mmu_start, busy,
           err_illegal, err_dropped, err_timeout
  );

  modport slave (
    input  host_instruction_valid, host_instruction, host_write_data,
           host_wdata_valid, host_write_address, mmu_done,
    output host_instruction_ready, weight_wr_en, weight_wr_row, weight_wr_col,
           weight_wr_data, ub_wr_en, ub_wr_addr, ub_wr_data, mmu_start, busy,
           err_illegal, err_dropped, err_timeout
  );
endinterface

// File: rtl/tpu_beat_counter.sv
// Loadable terminal-count counter; last_o flags the count one short of the terminal value.
module tpu_beat_counter #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] term_i,
  input  logic          inc_i,
  output logic [CW-1:0] count_o,
  output logic          last_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] term_q;

  // Count register: clear beats load beats increment; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      count_q <= {CW{1'b0}};
      term_q  <= {CW{1'b0}};
    end else if (clr_i) begin
      count_q <= {CW{1'b0}};
    end else if (load_i) begin
      count_q <= {CW{1'b0}};
      term_q  <= term_i;
    end else if (inc_i && (count_q != {CW{1'b1}})) begin
      count_q <= count_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_q <= count_q;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == (term_q - {{(CW-1){1'b0}}, 1'b1}));

endmodule

// File: rtl/tpu_host_ctrl.sv
// Host command front end: decodes host instructions, streams data beats into
// the weight buffer or UB, and launches/waits on the MMU.
module tpu_host_ctrl
  import tpu_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int DW          = DEF_DW,
  parameter int UB_AW       = DEF_UB_AW,
  parameter int MMU_TIMEOUT = DEF_MMU_TIMEOUT
) (
  input logic            clk,
  input logic            reset_n,
  tpu_host_ctrl_if.slave bus
);

  localparam int LG = $clog2(N);
  localparam logic [CNT_W-1:0] TILE_BEATS = CNT_W'(N * N);
  localparam logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(MMU_TIMEOUT);

  tpu_state_e       state_q, state_d;
  logic             ready_q, ready_d, busy_q, busy_d;
  logic             w_en_q, w_en_d, ub_en_q, ub_en_d, start_q, start_d;
  logic [LG-1:0]    w_row_q, w_row_d, w_col_q, w_col_d;
  logic [DW-1:0]    w_data_q, w_data_d, ub_data_q, ub_data_d;
  logic [UB_AW-1:0] ub_addr_q, ub_addr_d;
  logic             e_ill_q, e_ill_d, e_drop_q, e_drop_d, e_to_q, e_to_d;

  logic             cnt_clr_s, cnt_load_s, cnt_inc_s, cnt_last_s;
  logic [CNT_W-1:0] cnt_term_s, cnt_s;
  logic             instr_fire_s, beat_s;

  assign instr_fire_s = bus.host_instruction_valid && ready_q;
  assign beat_s       = bus.host_wdata_valid;

  tpu_beat_counter #(.CW(CNT_W)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (cnt_clr_s),
    .load_i  (cnt_load_s),
    .term_i  (cnt_term_s),
    .inc_i   (cnt_inc_s),
    .count_o (cnt_s),
    .last_o  (cnt_last_s)
  );

  // Next-state, next-output and counter control decode.
  always_comb begin
    state_d    = state_q;
    w_en_d     = 1'b0;
    ub_en_d    = 1'b0;
    start_d    = 1'b0;
    w_row_d    = w_row_q;
    w_col_d    = w_col_q;
    w_data_d   = w_data_q;
    ub_addr_d  = ub_addr_q;
    ub_data_d  = ub_data_q;
    e_ill_d    = e_ill_q;
    e_drop_d   = e_drop_q;
    e_to_d     = e_to_q;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    cnt_term_s = {CNT_W{1'b0}};
    case (state_q)
      IDLE: begin
        if (beat_s) e_drop_d = 1'b1;
        else        e_drop_d = e_drop_q;
        if (instr_fire_s) begin
          case (tpu_instruction_e'(get_opcode(bus.host_instruction)))
            NOP: state_d = IDLE;
            READ_WEIGHTS: begin
              state_d    = LOAD_W;
              cnt_load_s = 1'b1;
              cnt_term_s = TILE_BEATS;
            end
            READ_HOST_MEMORY: begin
              state_d    = LOAD_UB;
              cnt_load_s = 1'b1;
              cnt_term_s = get_beat_count(bus.host_instruction[IMM_MSB:0], TILE_BEATS);
            end
            MATRIX_MULTIPLY: begin
              state_d    = MMU_START;
              start_d    = 1'b1;
              cnt_load_s = 1'b1;
              cnt_term_s = TIMEOUT_CYC;
            end
            default: e_ill_d = 1'b1;
          endcase
        end else begin
          state_d = IDLE;
        end
      end
      LOAD_W: begin
        if (beat_s) begin
          // Row-major placement: upper counter bits select the row.
          w_en_d    = 1'b1;
          w_row_d   = cnt_s[2*LG-1:LG];
          w_col_d   = cnt_s[LG-1:0];
          w_data_d  = bus.host_write_data;
          cnt_inc_s = 1'b1;
          if (cnt_last_s) begin
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
          end else begin
            state_d = LOAD_W;
          end
        end else begin
          state_d = LOAD_W;
        end
      end
      LOAD_UB: begin
        if (beat_s) begin
          ub_en_d   = 1'b1;
          ub_addr_d = bus.host_write_address;
          ub_data_d = bus.host_write_data;
          cnt_inc_s = 1'b1;
          if (cnt_last_s) begin
            state_d   = IDLE;
            cnt_clr_s = 1'b1;
          end else begin
            state_d = LOAD_UB;
          end
        end else begin
          state_d = LOAD_UB;
        end
      end
      MMU_START: begin
        if (beat_s) e_drop_d = 1'b1;
        else        e_drop_d = e_drop_q;
        state_d = MMU_WAIT;
      end
      MMU_WAIT: begin
        if (beat_s) e_drop_d = 1'b1;
        else        e_drop_d = e_drop_q;
        if (bus.mmu_done) begin
          state_d   = IDLE;
          cnt_clr_s = 1'b1;
        end else if (cnt_last_s) begin
          state_d   = IDLE;
          e_to_d    = 1'b1;
          cnt_clr_s = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // State and registered outputs; reset drops any in-flight strobe.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q   <= IDLE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      w_en_q    <= 1'b0;
      ub_en_q   <= 1'b0;
      start_q   <= 1'b0;
      w_row_q   <= {LG{1'b0}};
      w_col_q   <= {LG{1'b0}};
      w_data_q  <= {DW{1'b0}};
      ub_addr_q <= {UB_AW{1'b0}};
      ub_data_q <= {DW{1'b0}};
      e_ill_q   <= 1'b0;
      e_drop_q  <= 1'b0;
      e_to_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      w_en_q    <= w_en_d;
      ub_en_q   <= ub_en_d;
      start_q   <= start_d;
      w_row_q   <= w_row_d;
      w_col_q   <= w_col_d;
      w_data_q  <= w_data_d;
      ub_addr_q <= ub_addr_d;
      ub_data_q <= ub_data_d;
      e_ill_q   <= e_ill_d;
      e_drop_q  <= e_drop_d;
      e_to_q    <= e_to_d;
    end
  end

  assign bus.host_instruction_ready = ready_q;
  assign bus.busy           = busy_q;
  assign bus.weight_wr_en   = w_en_q;
  assign bus.weight_wr_row  = w_row_q;
  assign bus.weight_wr_col  = w_col_q;
  assign bus.weight_wr_data = w_data_q;
  assign bus.ub_wr_en       = ub_en_q;
  assign bus.ub_wr_addr     = ub_addr_q;
  assign bus.ub_wr_data     = ub_data_q;
  assign bus.mmu_start      = start_q;
  assign bus.err_illegal    = e_ill_q;
  assign bus.err_dropped    = e_drop_q;
  assign bus.err_timeout    = e_to_q;

endmodule

// File: tb/tb_tpu_host_ctrl.sv
// Scoreboard bench for tpu_host_ctrl: expected strobes are queued as beats are driven.
module tb_tpu_host_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  tpu_host_ctrl_if bus ();

  tpu_host_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic        is_w;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   ub_strobes = 0;
  int   busy_cycles = 0;
  int   start_pulses = 0;
  int   snap_a, snap_b, snap_c;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    chk("ready_before_issue", 32'(bus.host_instruction_ready), 32'd1);
    bus.host_instruction       = ins;
    bus.host_instruction_valid = 1'b1;
    tick();
    bus.host_instruction_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d, input logic [11:0] a);
    bus.host_write_data    = d;
    bus.host_write_address = a;
    bus.host_wdata_valid   = 1'b1;
    tick();
    bus.host_wdata_valid   = 1'b0;
  endtask

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (!reset_n) begin
      busy_cycles  <= busy_cycles + int'(bus.busy);
      start_pulses <= start_pulses + int'(bus.mmu_start);
      if (bus.weight_wr_en === 1'b1) begin
        if (exp_q.size() == 0) chk("weight_unexpected", 32'd1, 32'd0);
        else begin
          got_e = exp_q.pop_front();
          chk("weight_kind", 32'd1, 32'(got_e.is_w));
          chk("weight_cell", 32'({bus.weight_wr_row, bus.weight_wr_col}), 32'(got_e.addr));
          chk("weight_data", 32'(bus.weight_wr_data), 32'(got_e.data));
        end
      end
      if (bus.ub_wr_en === 1'b1) begin
        ub_strobes <= ub_strobes + 1;
        if (exp_q.size() == 0) chk("ub_unexpected", 32'd1, 32'd0);
        else begin
          got_e = exp_q.pop_front();
          chk("ub_kind", 32'd0, 32'(got_e.is_w));
          chk("ub_addr", 32'(bus.ub_wr_addr), 32'(got_e.addr));
          chk("ub_data", 32'(bus.ub_wr_data), 32'(got_e.data));
        end
      end
    end
  end

  initial begin
    bus.host_instruction_valid = 1'b0;
    bus.host_instruction       = 32'd0;
    bus.host_write_data        = 8'd0;
    bus.host_wdata_valid       = 1'b0;
    bus.host_write_address     = 12'd0;
    bus.mmu_done               = 1'b0;
    reset_n = 1'b1;
    repeat (3) tick();
    reset_n = 1'b0;
    tick();

    chk("rst_ready", 32'(bus.host_instruction_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_errs", 32'({bus.err_illegal, bus.err_dropped, bus.err_timeout}), 32'd0);
    chk("rst_strobes", 32'({bus.weight_wr_en, bus.ub_wr_en, bus.mmu_start}), 32'd0);

    // Weight tile with one idle cycle between beats.
    issue(32'h4000_0000);
    chk("lw_busy", 32'(bus.busy), 32'd1);
    chk("lw_not_ready", 32'(bus.host_instruction_ready), 32'd0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back('{is_w: 1'b1, addr: 12'(r * 4 + c), data: 8'(r + 1)});
        beat(8'(r + 1), 12'hABC);
        if (r * 4 + c == 14) chk("lw_row3col2_mid_ready", 32'(bus.host_instruction_ready), 32'd0);
        if (r * 4 + c == 15) chk("lw_ready_after_16", 32'(bus.host_instruction_ready), 32'd1);
        tick();
      end
    end

    // Full-size UB load, back-to-back, then one extra beat in IDLE.
    issue(32'h2000_0000);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{is_w: 1'b0, addr: 12'(i), data: 8'(i + 1)});
      beat(8'(i + 1), 12'(i));
    end
    chk("ub16_ready", 32'(bus.host_instruction_ready), 32'd1);
    chk("drop_before", 32'(bus.err_dropped), 32'd0);
    beat(8'hEE, 12'd99);
    chk("drop_after", 32'(bus.err_dropped), 32'd1);
    tick();

    // Short UB load of three beats.
    snap_a = ub_strobes;
    issue(32'h2000_0003);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{is_w: 1'b0, addr: 12'(12'h100 + i), data: 8'(8'h80 + i)});
      beat(8'(8'h80 + i), 12'(12'h100 + i));
    end
    chk("ub3_ready", 32'(bus.host_instruction_ready), 32'd1);
    tick();
    tick();
    chk("ub3_count", 32'(ub_strobes - snap_a), 32'd3);

    // MMU launch with completion sampled 11 edges after acceptance.
    snap_b = busy_cycles;
    snap_c = start_pulses;
    issue(32'h6000_0000);
    chk("mmu_start_hi", 32'(bus.mmu_start), 32'd1);
    tick();
    chk("mmu_start_lo", 32'(bus.mmu_start), 32'd0);
    repeat (9) tick();
    bus.mmu_done = 1'b1;
    tick();
    bus.mmu_done = 1'b0;
    chk("mmu_ready", 32'(bus.host_instruction_ready), 32'd1);
    tick();
    chk("mmu_busy_cycles", 32'(busy_cycles - snap_b), 32'd11);
    chk("mmu_pulses", 32'(start_pulses - snap_c), 32'd1);
    chk("mmu_no_timeout", 32'(bus.err_timeout), 32'd0);

    // MMU never completes.
    snap_b = busy_cycles;
    issue(32'h6000_0000);
    for (int i = 0; i < 400 && !bus.host_instruction_ready; i++) tick();
    chk("to_back_idle", 32'(bus.host_instruction_ready), 32'd1);
    chk("to_flag", 32'(bus.err_timeout), 32'd1);
    tick();
    chk("to_busy_cycles", 32'(busy_cycles - snap_b), 32'd257);

    // Illegal opcode.
    issue(32'hE000_0000);
    chk("ill_flag", 32'(bus.err_illegal), 32'd1);
    chk("ill_idle", 32'({bus.busy, bus.host_instruction_ready}), 32'b01);

    // Reset in the middle of a weight load.
    issue(32'h4000_0000);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back('{is_w: 1'b1, addr: 12'(i), data: 8'(8'h10 + i)});
      beat(8'(8'h10 + i), 12'd0);
    end
    tick();
    reset_n = 1'b1;
    tick();
    reset_n = 1'b0;
    chk("mid_rst_errs", 32'({bus.err_illegal, bus.err_dropped, bus.err_timeout}), 32'd0);
    chk("mid_rst_ready", 32'(bus.host_instruction_ready), 32'd1);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    issue(32'h4000_0000);
    exp_q.push_back('{is_w: 1'b1, addr: 12'd0, data: 8'h55});
    beat(8'h55, 12'd7);
    tick();
    tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/tpu_host_ctrl.md
# tpu_host_ctrl

Host-side command front end of the TPU: accepts 32-bit host instructions over a valid/ready handshake and sequences the following host data beats into the weight buffer or the unified buffer (UB). It also launches the matrix-multiply unit (MMU) and waits for its completion. It sits directly upstream of the systolic array / UB core and drives its load and start ports.

## Interface
Parameters:
- N, 4, systolic array dimension; the weight tile is N×N.
- DW, 8, data width of one host beat (signed byte).
- UB_AW, 12, UB address width.
- MMU_TIMEOUT, 256, maximum cycles to wait for mmu_done.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  synchronous, active-high reset: reset_n=1 at a clk edge resets the block. The name is kept for the codebase; the polarity is fixed as active-high.
- host_instruction_valid  in  1  instruction offered.
- host_instruction  in  32  {opcode[31:29], imm[28:0]}.
- host_instruction_ready  out  1  instruction accepted when valid&&ready.
- host_write_data  in  DW  data beat.
- host_wdata_valid  in  1  data beat valid; there is no backpressure.
- host_write_address  in  UB_AW  UB address of the beat.
- weight_wr_en  out  1  weight write strobe.
- weight_wr_row, weight_wr_col  out  $clog2(N) each  target weight cell.
- weight_wr_data  out  DW  weight value.
- ub_wr_en  out  1  UB write strobe.
- ub_wr_addr  out  UB_AW  UB address.
- ub_wr_data  out  DW  UB value.
- mmu_start  out  1  one-cycle launch pulse.
- mmu_done  in  1  completion from the MMU.
- busy  out  1  state != IDLE.
- err_illegal, err_dropped, err_timeout  out  1 each  sticky error flags, cleared only by reset.

## Operation
- Opcodes, from tpu_instruction_e (3 bits):
  - NOP=0
  - READ_HOST_MEMORY=1
  - READ_WEIGHTS=2
  - MATRIX_MULTIPLY=3
  - 4–7 are illegal.
- FSM states: IDLE, LOAD_W, LOAD_UB, MMU_START, MMU_WAIT.
- IDLE:
  - ready=1.
  - On an accepted instruction: READ_WEIGHTS→LOAD_W, READ_HOST_MEMORY→LOAD_UB, MATRIX_MULTIPLY→MMU_START.
  - NOP stays in IDLE.
  - An illegal opcode sets err_illegal and stays in IDLE.
- LOAD_W:
  - Accepts exactly N*N beats, row-major; a beat counter supplies row and col.
  - host_write_address is ignored.
  - After beat N*N-1 → IDLE.
- LOAD_UB:
  - Beat count is imm[11:0]; 0 means N*N.
  - Each beat writes ub_wr_addr=host_write_address.
  - After the final beat → IDLE.
- MMU_START: mmu_start=1 for exactly one cycle → MMU_WAIT.
- MMU_WAIT:
  - mmu_done=1 → IDLE.
  - A cycle counter reaching MMU_TIMEOUT sets err_timeout → IDLE.
- Data beats arriving in IDLE, MMU_START or MMU_WAIT are discarded and set err_dropped. This includes a beat in the same cycle as an accepted instruction.
- Instructions are ignored (ready=0) in every state except IDLE.
- The beat counter is $clog2(N*N)+… wide enough for 4095 and never wraps; it is cleared on every entry to IDLE.

## Timing
- Reset values: all outputs 0, except host_instruction_ready=1. State IDLE, counters 0.
- Instruction accepted at edge k → new state from edge k; ready=0 from edge k.
- Write outputs are registered. A beat sampled at edge k drives wr_en/addr/data during cycle k..k+1 (1-cycle latency). wr_en is high for exactly one cycle per beat.
- Back-to-back beats on consecutive cycles are supported at full rate.
- Final load beat at edge k → IDLE and ready=1 from edge k. A new instruction can be accepted at edge k+1.
- MATRIX_MULTIPLY accepted at edge k → mmu_start high for cycle k..k+1.
- mmu_done is sampled from edge k+2 onward. If mmu_done is high at edge m, the state is IDLE from edge m.
- Reset mid-operation returns the block to IDLE in the same edge. Partially loaded data is not rolled back, and no further strobes are issued.

## Structure
- tpu_pkg holds:
  - tpu_instruction_e
  - the FSM state typedef
  - N, DW, UB_AW defaults
  - opcode field positions
- One sub-module, tpu_beat_counter: a loadable terminal-count counter with a done flag. It is used for both load beat counting and the MMU timeout.

## Test plan
- READ_WEIGHTS, then B rows {1,1,1,1},{2,2,2,2},{3,3,3,3},{4,4,4,4} with gaps → 16 weight strobes. Row 3 col 2 carries data 4. ready returns 1 after the 16th beat.
- READ_HOST_MEMORY imm=0, then 16 beats with addresses 0..15 and values 1..16 → ub_wr_addr=i, ub_wr_data=i+1. The 17th beat is dropped and sets err_dropped.
- READ_HOST_MEMORY imm=3 with back-to-back beats → exactly 3 UB strobes, then IDLE.
- MATRIX_MULTIPLY with mmu_done pulsed 10 cycles later → one mmu_start pulse. busy=1 for 11 cycles, then ready=1. err_timeout=0.
- MATRIX_MULTIPLY with mmu_done never asserted → err_timeout=1 after 256 wait cycles, then IDLE.
- Opcode 7 → err_illegal=1, state stays IDLE. Reset asserted mid LOAD_W after 5 beats → all flags 0, ready=1, and the next READ_WEIGHTS restarts at row 0 col 0.
